// File: rtl/power532_pkg.sv
// Shared width helpers for the pipelined integer power unit.
package power532_pkg;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_EXP   = 3;
  localparam int unsigned DEF_TAG_W = 4;

  // Full-precision result width of in^n_exp.
  function automatic int unsigned out_w(input int unsigned in_w, input int unsigned n_exp);
    return in_w * n_exp;
  endfunction

  // Accumulator width held by stage idx (holds in^(idx+1)).
  function automatic int unsigned stage_w(input int unsigned in_w, input int unsigned idx);
    return in_w * (idx + 1);
  endfunction

  // Bit offset of stage idx inside the flattened accumulator bus.
  function automatic int unsigned acc_off(input int unsigned in_w, input int unsigned idx);
    return (in_w * idx * (idx + 1)) / 2;
  endfunction

  // Tag width guard so a zero-width sideband never reaches a port.
  function automatic int unsigned tag_w(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pow_stage532.sv
// One power-pipe stage: holds x and the running product, advances under the ready chain.
module pow_stage532
  import power532_pkg::*;
#(
  parameter  int unsigned IN_W   = 8,
  parameter  int unsigned IDX    = 0,
  parameter  int unsigned SIGNED = 0,
  parameter  int unsigned TAG_W  = 4,
  localparam int unsigned AI_W   = (IDX == 0) ? IN_W : stage_w(IN_W, IDX - 1),
  localparam int unsigned AO_W   = stage_w(IN_W, IDX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              v_i,
  input  logic [IN_W-1:0]   x_i,
  input  logic [AI_W-1:0]   acc_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              rdy_nxt_i,
  output logic              rdy_o,
  output logic              v_o,
  output logic [IN_W-1:0]   x_o,
  output logic [AO_W-1:0]   acc_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic              v_q, v_d;
  logic [IN_W-1:0]   x_q, x_d;
  logic [AO_W-1:0]   acc_q, acc_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [AO_W-1:0]   prod_c;
  logic              load_c;

  assign rdy_o  = ~v_q | rdy_nxt_i;
  assign load_c = rdy_o & v_i;

  if (IDX == 0) begin : g_load
    assign prod_c = acc_i;
  end else begin : g_mul
    // Extending both operands to the stage width keeps the low product bits exact
    // for either signedness, and the true result always fits.
    logic            a_sx, x_sx;
    logic [AO_W-1:0] a_ext, x_ext;
    assign a_sx   = (SIGNED != 0) & acc_i[AI_W-1];
    assign x_sx   = (SIGNED != 0) & x_i[IN_W-1];
    assign a_ext  = {{(AO_W - AI_W){a_sx}}, acc_i};
    assign x_ext  = {{(AO_W - IN_W){x_sx}}, x_i};
    assign prod_c = a_ext * x_ext;
  end

  always_comb begin
    v_d   = v_q;
    x_d   = x_q;
    acc_d = acc_q;
    tag_d = tag_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (rdy_o) begin
      v_d = v_i;
    end
    if (load_c) begin
      x_d   = x_i;
      acc_d = prod_c;
      tag_d = tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      x_q   <= '0;
      acc_q <= '0;
      tag_q <= '0;
    end else begin
      v_q   <= v_d;
      x_q   <= x_d;
      acc_q <= acc_d;
      tag_q <= tag_d;
    end
  end

  assign v_o   = v_q;
  assign x_o   = x_q;
  assign acc_o = acc_q;
  assign tag_o = tag_q;

endmodule

// File: rtl/power_pipe532.sv
// Pipelined integer power unit: out_data = in_data^EXP at full precision, one result per cycle,
// valid/ready on both sides with a pass-through tag, flush and busy flag.
module power_pipe532
  import power532_pkg::*;
#(
  parameter  int unsigned IN_W   = DEF_IN_W,
  parameter  int unsigned EXP    = DEF_EXP,
  parameter  int unsigned SIGNED = 0,
  parameter  int unsigned TAG_W  = DEF_TAG_W,
  localparam int unsigned OUT_W  = out_w(IN_W, EXP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int unsigned ACC_W = acc_off(IN_W, EXP);

  logic [EXP-1:0]          v;
  logic [EXP:0]            rdy;
  logic [ACC_W-1:0]        acc_all;
  logic [IN_W*(EXP-1)-1:0] x_all;
  logic [IN_W-1:0]         x_tail_unused;
  logic [TAG_W*EXP-1:0]    tag_all;

  assign rdy[EXP] = out_ready;

  for (genvar i = 0; i < int'(EXP); i++) begin : g_st
    localparam int unsigned AI_W = (i == 0) ? IN_W : stage_w(IN_W, i - 1);
    localparam int unsigned AO_W = stage_w(IN_W, i);

    logic              v_in;
    logic [IN_W-1:0]   x_in;
    logic [AI_W-1:0]   acc_in;
    logic [TAG_W-1:0]  tag_in;
    logic [IN_W-1:0]   x_out;

    if (i == 0) begin : g_head
      assign v_in   = in_valid;
      assign x_in   = in_data;
      assign acc_in = in_data;
      assign tag_in = in_tag;
    end else begin : g_body
      assign v_in   = v[i-1];
      assign x_in   = x_all[(i-1)*IN_W +: IN_W];
      assign acc_in = acc_all[acc_off(IN_W, i - 1) +: AI_W];
      assign tag_in = tag_all[(i-1)*TAG_W +: TAG_W];
    end

    // The last stage's x copy has no consumer.
    if (i < int'(EXP) - 1) begin : g_fwd
      assign x_all[i*IN_W +: IN_W] = x_out;
    end else begin : g_tail
      assign x_tail_unused = x_out;
    end

    pow_stage532 #(
      .IN_W   (IN_W),
      .IDX    (i),
      .SIGNED (SIGNED),
      .TAG_W  (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush),
      .v_i       (v_in),
      .x_i       (x_in),
      .acc_i     (acc_in),
      .tag_i     (tag_in),
      .rdy_nxt_i (rdy[i+1]),
      .rdy_o     (rdy[i]),
      .v_o       (v[i]),
      .x_o       (x_out),
      .acc_o     (acc_all[acc_off(IN_W, i) +: AO_W]),
      .tag_o     (tag_all[i*TAG_W +: TAG_W])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[EXP-1];
  assign out_data  = acc_all[acc_off(IN_W, EXP - 1) +: OUT_W];
  assign out_tag   = tag_all[(EXP-1)*TAG_W +: TAG_W];
  assign busy      = |v;

endmodule

// File: tb/tb_power_pipe532.sv
// Directed bench for power_pipe532: scoreboarded unsigned cube stream plus signed and EXP=4 shots.
module tb_power_pipe532;

  typedef struct packed {
    logic [3:0]  tag;
    logic [23:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  // u0: IN_W=8, EXP=3, unsigned
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;

  // u1: IN_W=8, EXP=3, signed
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_in_data = '0;
  logic [3:0]  s_in_tag = 4'h3;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [23:0] s_out_data;
  logic [3:0]  s_out_tag;
  logic        s_busy;

  // u2: IN_W=4, EXP=4, unsigned
  logic        p_in_valid = 1'b0;
  logic        p_in_ready;
  logic [3:0]  p_in_data = '0;
  logic [3:0]  p_in_tag = 4'h9;
  logic        p_out_valid;
  logic        p_out_ready = 1'b1;
  logic [15:0] p_out_data;
  logic [3:0]  p_out_tag;
  logic        p_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_dlv    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  power_pipe532 #(.IN_W(8), .EXP(3), .SIGNED(0), .TAG_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  power_pipe532 #(.IN_W(8), .EXP(3), .SIGNED(1), .TAG_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_tag(s_out_tag),
    .busy(s_busy)
  );

  power_pipe532 #(.IN_W(4), .EXP(4), .SIGNED(0), .TAG_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_tag(p_in_tag),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_tag(p_out_tag),
    .busy(p_busy)
  );

  function automatic logic [23:0] cube8(input logic [7:0] v);
    longint unsigned t;
    t = 64'(v);
    return 24'(t * t * t);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u0: pop on delivery first (older entry), then push on acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("sb_expected_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.data));
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
        end
        n_dlv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{tag: in_tag, data: cube8(in_data)});
        n_acc++;
      end
    end
  end

  task automatic sgn_shot(input logic [7:0] d, input logic [23:0] e, input string tag);
    s_in_valid = 1'b1;
    s_in_data  = d;
    tick();
    s_in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_valid"}, 64'(s_out_valid), 64'd1);
    chk({tag, "_data"}, 64'(s_out_data), 64'(e));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    int   a0;
    logic fire;
    logic [23:0] held;
    held = '0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_s_out_data", 64'(s_out_data), 64'd0);
    chk("rst_p_out_valid", 64'(p_out_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single shot 255^3 with exact latency
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_tag   = 4'h5;
    tick();
    in_valid = 1'b0;
    chk("t1_busy_on", 64'(busy), 64'd1);
    chk("t1_ov_edge1", 64'(out_valid), 64'd0);
    tick();
    chk("t1_ov_edge2", 64'(out_valid), 64'd0);
    tick();
    chk("t1_ov_edge3", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h00FD02FF);
    chk("t1_tag", 64'(out_tag), 64'h5);
    tick();
    chk("t1_busy_off", 64'(busy), 64'd0);
    chk("t1_ov_off", 64'(out_valid), 64'd0);

    // Signed corner operands
    sgn_shot(8'h80, 24'hE00000, "sgn_min");
    sgn_shot(8'hFF, 24'hFFFFFF, "sgn_m1");
    sgn_shot(8'h7F, 24'h1F417F, "sgn_max");

    // EXP=4, IN_W=4: 15^4 with four-edge latency
    p_in_valid = 1'b1;
    p_in_data  = 4'hF;
    tick();
    p_in_valid = 1'b0;
    tick();
    tick();
    chk("p_ov_edge3", 64'(p_out_valid), 64'd0);
    tick();
    chk("p_ov_edge4", 64'(p_out_valid), 64'd1);
    chk("p_data", 64'(p_out_data), 64'hC5C1);
    chk("p_tag", 64'(p_out_tag), 64'h9);
    tick();
    chk("p_busy_off", 64'(p_busy), 64'd0);

    // Back-to-back stream 0..255: every result delivered, one per cycle
    d0 = n_dlv;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_tag   = 4'(i % 16);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t2_delivered", 64'(n_dlv - d0), 64'd256);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    chk("t2_busy_off", 64'(busy), 64'd0);

    // Backpressure: out_ready low for 10 cycles while offering operands
    a0        = n_acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd10;
    in_tag    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        in_data++;
        in_tag++;
      end
      if (i == 3) held = out_data;
    end
    chk("t3_accepted", 64'(n_acc - a0), 64'd3);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_out_stable", 64'(out_data), 64'(held));
    chk("t3_head_data", 64'(out_data), 64'(cube8(8'd10)));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    d0 = n_dlv;
    tick();
    tick();
    tick();
    chk("t3_drained", 64'(n_dlv - d0), 64'd3);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    chk("t3_busy_off", 64'(busy), 64'd0);

    // Async reset with two operands in flight
    in_valid = 1'b1;
    in_data  = 8'd200;
    tick();
    in_data  = 8'd201;
    tick();
    in_valid = 1'b0;
    chk("t6r_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6r_out_valid", 64'(out_valid), 64'd0);
    chk("t6r_busy", 64'(busy), 64'd0);
    chk("t6r_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    d0 = n_dlv;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6r_nothing_out", 64'(n_dlv - d0), 64'd0);

    // Flush with two operands in flight and a simultaneous offer
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    in_data  = 8'd51;
    tick();
    in_data  = 8'd52;
    flush    = 1'b1;
    #1;
    chk("t6f_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6f_busy", 64'(busy), 64'd0);
    chk("t6f_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    d0 = n_dlv;
    repeat (5) tick();
    chk("t6f_nothing_out", 64'(n_dlv - d0), 64'd0);
    chk("t6f_in_ready_after", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
